modexp_ct: RTL and testbench

MODEXP_CT -- requirements
Module: modexp_ct

---
 rtl/modexp_ct.sv | 182 ++++++++++++++++++
 tb/tb_modexp_ct.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/modexp_ct.sv
// Modular exponentiation (Montgomery-ladder order, MSB first) built from two
// interleaved shift-add modular multipliers; ct_mode fixes latency regardless of operands.
module modexp_ct #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned EXP_WIDTH = 8,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 ct_mode,
  input  logic [WIDTH-1:0]     base,
  input  logic [EXP_WIDTH-1:0] exp,
  input  logic [WIDTH-1:0]     modulus,
  output logic [WIDTH-1:0]     result,
  output logic                 done,
  output logic                 busy,
  output logic                 err,
  output logic [CNT_W-1:0]     cycle_cnt
);

  localparam int unsigned ACC_W = WIDTH + 2;
  localparam int unsigned MC_W  = $clog2(WIDTH + 1);
  localparam int unsigned BC_W  = $clog2(EXP_WIDTH + 1);

  typedef enum logic [2:0] {IDLE, CHECK, SKIP, MUL, UPDATE, DONE} state_t;

  state_t state_q, state_d;

  logic [WIDTH-1:0]     base_r, mod_r, r0, r1;
  logic [EXP_WIDTH-1:0] exp_r;
  logic                 ct_r;
  logic [ACC_W-1:0]     acc0, acc1;
  logic [MC_W-1:0]      mcnt;
  logic [BC_W-1:0]      bcnt;

  logic             operand_err, k, mul_last, accept;
  logic [WIDTH-1:0] a0_op, b0_op, a1_op, b1_op, a0_shl, a1_shl;

  // One step of a shift-add modular multiply: acc = 2*acc (+b) mod n.
  function automatic logic [ACC_W-1:0] mod_step(input logic [ACC_W-1:0] acc,
                                                input logic             bit_a,
                                                input logic [WIDTH-1:0] b,
                                                input logic [WIDTH-1:0] n);
    logic [ACC_W-1:0] t, n_e;
    n_e = ACC_W'(n);
    t   = acc << 1;
    if (t >= n_e) t = t - n_e;
    if (bit_a) t = t + ACC_W'(b);
    if (t >= n_e) t = t - n_e;
    return t;
  endfunction

  assign operand_err = (mod_r == '0) || (base_r >= mod_r);
  assign k           = exp_r[EXP_WIDTH-1];
  assign mul_last    = (mcnt == MC_W'(WIDTH - 1));

  // Ladder operand routing: multiplier 0 produces the new R0, multiplier 1 the new R1.
  assign a0_op  = r0;
  assign b0_op  = k ? r1 : r0;
  assign a1_op  = k ? r1 : r0;
  assign b1_op  = r1;
  assign a0_shl = a0_op << mcnt;
  assign a1_shl = a1_op << mcnt;

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (operand_err)   state_d = DONE;
        else if (ct_r || k) state_d = MUL;
        else               state_d = SKIP;
      end
      SKIP: begin
        if (bcnt == BC_W'(1))           state_d = DONE;
        else if (exp_r[EXP_WIDTH-2])    state_d = MUL;
      end
      MUL:    if (mul_last) state_d = UPDATE;
      UPDATE: state_d = (bcnt == BC_W'(1)) ? DONE : MUL;
      DONE:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, ladder registers and multiplier datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_r <= '0;
      mod_r  <= '0;
      exp_r  <= '0;
      ct_r   <= 1'b0;
      r0     <= '0;
      r1     <= '0;
      acc0   <= '0;
      acc1   <= '0;
      mcnt   <= '0;
      bcnt   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            base_r <= base;
            mod_r  <= modulus;
            exp_r  <= exp;
            ct_r   <= ct_mode;
            bcnt   <= BC_W'(EXP_WIDTH);
            acc0   <= '0;
            acc1   <= '0;
            mcnt   <= '0;
          end
        end
        CHECK: begin
          if (!operand_err) begin
            r0 <= (mod_r == WIDTH'(1)) ? '0 : WIDTH'(1);
            r1 <= base_r;
          end
        end
        SKIP: begin
          exp_r <= exp_r << 1;
          bcnt  <= bcnt - BC_W'(1);
        end
        MUL: begin
          acc0 <= mod_step(acc0, a0_shl[WIDTH-1], b0_op, mod_r);
          acc1 <= mod_step(acc1, a1_shl[WIDTH-1], b1_op, mod_r);
          mcnt <= mcnt + MC_W'(1);
        end
        UPDATE: begin
          r0    <= WIDTH'(acc0);
          r1    <= WIDTH'(acc1);
          acc0  <= '0;
          acc1  <= '0;
          mcnt  <= '0;
          exp_r <= exp_r << 1;
          bcnt  <= bcnt - BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Registered status outputs; result/err load on entry to DONE and hold afterwards.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      err       <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      done <= (state_d == DONE);
      busy <= (state_d != IDLE);
      if (accept) begin
        cycle_cnt <= '0;
        result    <= '0;
        err       <= 1'b0;
      end else if (busy && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      end
      if (state_d == DONE) begin
        case (state_q)
          CHECK:  begin result <= '0;            err <= 1'b1; end
          SKIP:   begin result <= r0;            err <= 1'b0; end
          UPDATE: begin result <= WIDTH'(acc0);  err <= 1'b0; end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_modexp_ct.sv
// Bench for modexp_ct: arithmetic reference model with a per-cycle protocol checker,
// plus directed vectors with hand-computed results and latencies.
module tb_modexp_ct;

  localparam int unsigned W  = 8;
  localparam int unsigned EW = 8;
  localparam int unsigned CW = 16;

  localparam int M_IDLE = 0;
  localparam int M_BUSY = 1;
  localparam int M_DONE = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          ct_mode = 1'b1;
  logic [W-1:0]  base = '0, modulus = '0;
  logic [EW-1:0] exp_a = '0, exp_b = '0;

  logic [W-1:0]  result_a, result_b;
  logic          done_a, done_b, busy_a, busy_b, err_a, err_b;
  logic [CW-1:0] cnt_a, cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  int     phase = M_IDLE;
  int     m_cnt = 0, m_lat = 0;
  int     m_res = 0, m_err = 0;
  longint cyc = 0, done_a_cyc = -1, done_b_cyc = -2;

  modexp_ct #(.WIDTH(W), .EXP_WIDTH(EW), .CNT_W(CW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .ct_mode(ct_mode), .base(base), .exp(exp_a),
    .modulus(modulus), .result(result_a), .done(done_a), .busy(busy_a), .err(err_a),
    .cycle_cnt(cnt_a)
  );

  modexp_ct #(.WIDTH(W), .EXP_WIDTH(EW), .CNT_W(CW)) dut_b (
    .clk(clk), .rst(rst), .start(start), .ct_mode(ct_mode), .base(base), .exp(exp_b),
    .modulus(modulus), .result(result_b), .done(done_b), .busy(busy_b), .err(err_b),
    .cycle_cnt(cnt_b)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int ref_modexp(input int unsigned b, input int unsigned e, input int unsigned n);
    longint r, x;
    if (n == 0 || b >= n) return 0;
    r = 1 % n;
    x = b % n;
    for (int i = 0; i < int'(EW); i++) begin
      if (e[i]) r = (r * x) % n;
      x = (x * x) % n;
    end
    return int'(r);
  endfunction

  function automatic int ref_lat(input int unsigned b, input int unsigned e,
                                 input int unsigned n, input bit ct);
    int lz = 0;
    if (n == 0 || b >= n) return 2;
    if (ct) return int'(EW * (W + 1) + 2);
    for (int i = int'(EW) - 1; i >= 0; i--) begin
      if (e[i]) break;
      lz++;
    end
    return 2 + lz + (int'(EW) - lz) * int'(W + 1);
  endfunction

  // Protocol model: tracks acceptance and expected done cycle, checks dut_a every cycle.
  always @(posedge clk) begin
    bit post, rst_seen;
    post = 1'b0;
    rst_seen = 1'b0;
    if (rst) begin
      phase = M_IDLE;
      rst_seen = 1'b1;
    end else if (phase == M_DONE) begin
      phase = M_IDLE;
      post = 1'b1;
    end else if (phase == M_IDLE && start) begin
      m_lat = ref_lat(base, exp_a, modulus, ct_mode);
      m_res = ref_modexp(base, exp_a, modulus);
      m_err = (modulus == 0 || base >= modulus) ? 1 : 0;
      m_cnt = 0;
      phase = M_BUSY;
    end
    #1;
    cyc++;
    if (done_a) done_a_cyc = cyc;
    if (done_b) done_b_cyc = cyc;
    if (rst_seen) begin
      check("reset_outputs", {result_a, err_a, done_a, busy_a, cnt_a}, 64'd0);
    end else if (phase == M_BUSY) begin
      m_cnt++;
      if (m_cnt == m_lat) begin
        check("done_pulse", {done_a, busy_a}, 64'd3);
        check("result", result_a, m_res);
        check("err", err_a, m_err);
        phase = M_DONE;
      end else begin
        check("busy_no_done", {done_a, busy_a}, 64'd1);
      end
    end else if (post) begin
      check("cycle_cnt", cnt_a, m_lat);
      check("held_result", {result_a, err_a}, {m_res[W-1:0], m_err[0]});
      check("idle_after_done", {done_a, busy_a}, 64'd0);
    end else begin
      check("idle", {done_a, busy_a}, 64'd0);
    end
  end

  task automatic launch(input int unsigned b, input int unsigned e, input int unsigned n,
                        input bit ct, input int unsigned eb);
    base    = W'(b);
    exp_a   = EW'(e);
    exp_b   = EW'(eb);
    modulus = W'(n);
    ct_mode = ct;
    start   = 1'b1;
    @(negedge clk);
    start   = 1'b0;
  endtask

  task automatic wait_idle(input bit noise);
    int g = 0;
    while (phase != M_IDLE && g < 3000) begin
      if (noise) begin
        start   = 1'($urandom_range(0, 1));
        base    = W'($urandom);
        exp_a   = EW'($urandom);
        modulus = W'($urandom);
        ct_mode = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      g++;
    end
    start = 1'b0;
    check("wait_bound", g < 3000, 1);
  endtask

  initial begin
    int unsigned n, b, e;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Small vector, constant-time: 2^10 mod 143 = 23 in 74 cycles.
    launch(2, 10, 143, 1'b1, 10);
    wait_idle(1'b0);
    check("vec_ct_result", result_a, 23);
    check("vec_ct_cnt", cnt_a, 74);
    check("vec_ct_err", err_a, 0);

    // Same operands in fast mode: 4 leading zeros -> 2+4+4*9 = 42.
    launch(2, 10, 143, 1'b0, 10);
    wait_idle(1'b0);
    check("vec_fast_result", result_a, 23);
    check("vec_fast_cnt", cnt_a, 42);

    // Fast mode with exp=0: 2+8 cycles, result 1.
    launch(2, 0, 143, 1'b0, 0);
    wait_idle(1'b0);
    check("vec_exp0_result", result_a, 1);
    check("vec_exp0_cnt", cnt_a, 10);

    // Timing non-interference: 65^1 and 65^255 mod 143 (both 65) finish together.
    done_a_cyc = -1;
    done_b_cyc = -2;
    launch(65, 8'h01, 143, 1'b1, 8'hFF);
    wait_idle(1'b0);
    check("ni_same_done_cycle", done_a_cyc, done_b_cyc);
    check("ni_cnt_a", cnt_a, 74);
    check("ni_cnt_b", cnt_b, 74);
    check("ni_result_a", result_a, 65);
    check("ni_result_b", result_b, 65);

    // Error paths and modulus == 1.
    launch(5, 3, 0, 1'b1, 3);
    wait_idle(1'b0);
    check("err_mod0", {err_a, result_a}, {1'b1, 8'd0});
    check("err_mod0_cnt", cnt_a, 2);
    launch(200, 3, 143, 1'b0, 3);
    wait_idle(1'b0);
    check("err_base_ge", {err_a, result_a}, {1'b1, 8'd0});
    check("err_base_ge_cnt", cnt_a, 2);
    launch(0, 5, 1, 1'b1, 5);
    wait_idle(1'b0);
    check("mod1", {err_a, result_a}, {1'b0, 8'd0});

    // Reset abort around cycle 30, then a clean rerun.
    launch(7, 8'hA5, 221, 1'b1, 8'hA5);
    repeat (29) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (80) @(negedge clk);
    check("abort_no_done_cnt", cnt_a, 0);
    launch(7, 8'hA5, 221, 1'b1, 8'hA5);
    wait_idle(1'b0);
    check("abort_rerun_cnt", cnt_a, 74);

    // start together with rst is ignored.
    rst = 1'b1;
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("start_in_rst_busy", busy_a, 0);

    // start held high: DONE-cycle start ignored, next-cycle start accepted.
    base = 3; exp_a = 8'h81; exp_b = 8'h81; modulus = 250; ct_mode = 1'b1;
    start = 1'b1;
    repeat (80) @(negedge clk);
    start = 1'b0;
    wait_idle(1'b0);
    check("held_start_cnt", cnt_a, 74);

    // Random sweep with start noise while busy.
    for (int i = 0; i < 24; i++) begin
      n = $urandom_range(2, 255);
      b = $urandom_range(0, n - 1);
      e = $urandom_range(0, 255);
      launch(b, e, n, 1'($urandom_range(0, 1)), e);
      wait_idle(1'b1);
    end

    repeat (3) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
